alsu_disp_ctrl: RTL
===================

ALSU_DISP_CTRL -- requirements
Module: alsu_disp_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit (min 2).
REQ-002 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (min 2).
REQ-003 Parameter ERR_BLINKS, default 4, full on/off blink periods per error episode (min 1).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 res_in  input  6  ALSU result value.
REQ-007 res_valid  input  1  one-cycle strobe: res_in holds a new result.
REQ-008 err_in  input  1  one-cycle strobe: ALSU flagged an invalid operation.
REQ-009 anode  output  4  digit enables, active-low, one-hot-low when lit; bit0 = rightmost digit.
REQ-010 cathode  output  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-low.
REQ-011 leds  output  16  error-blink LEDs, active-high.

Function
REQ-012 States: IDLE (no result yet), SHOW (result displayed), ERR (error blink).
REQ-013 res_valid high -> res_in captured into value register on same edge, in any state; a flag records that a value exists.
REQ-014 IDLE -> SHOW on the edge capturing res_valid; IDLE or SHOW -> ERR on err_in.
REQ-015 err_in and res_valid in same cycle: value captured AND state goes to ERR (error wins display).
REQ-016 err_in while in ERR: blink counter, phase and period count restart; phase forced ON.
REQ-017 ERR exit after 2*ERR_BLINKS phase toggles: to SHOW if a value exists, else IDLE; leds cleared on exit.
REQ-018 Scan: refresh counter 0..REFRESH_DIV-1; at terminal count wraps to 0 and digit index advances 0->1->2->3->0.
REQ-019 anode and cathode registered; both update on the same edge as the digit index change; anode never has >1 bit low.
REQ-020 IDLE: all four digits show dash (7'b1111110).
REQ-021 SHOW: digit0 = hex of value[3:0], digit1 = hex of {2'b00,value[5:4]}, digits 2,3 blank (7'b1111111).
REQ-022 ERR phase ON: digits 3..0 show "E","r","r",blank; leds = 16'hFFFF.
REQ-023 ERR phase OFF: all cathode = 7'b1111111 (anode still scans); leds = 16'h0000.
REQ-024 Blink counter 0..BLINK_DIV-1 runs only in ERR; phase toggles at terminal count; phase ON at ERR entry.
REQ-025 Value update latency: captured value visible on cathode at the next digit-index advance selecting that digit; mid-slot cathode does not change.
REQ-026 Hex codes (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; r=1111010.

Reset
REQ-027 rst asserted: state IDLE, value 0, value-exists flag 0, counters 0, digit index 0, phase ON.
REQ-028 rst asserted: anode = 4'b1111, cathode = 7'b1111111, leds = 16'h0000, immediately (asynchronous).
REQ-029 rst mid-ERR or mid-scan: all progress discarded; first lit digit after release is digit0 showing dash.

Structure
REQ-030 Package alsu_pkg holds state encoding and segment constants SEG_BLANK, SEG_DASH, SEG_E, SEG_R.
REQ-031 Sub-module seg7_hex_dec: combinational 4-bit -> 7-bit active-low hex decoder per REQ-026.
REQ-032 Block sits directly downstream of the ALSU and is the sole driver of board anode/cathode/leds.

Verification (REFRESH_DIV=4, BLINK_DIV=8, ERR_BLINKS=2)
REQ-033 Reset release, no strobes -> anode cycles 1110,1101,1011,0111 every 4 clks, cathode 1111110 each.
REQ-034 res_valid with res_in=6'h2D -> digit0 cathode 1000010 ("d"), digit1 0010010 ("2"), digits 2,3 1111111.
REQ-035 err_in after 6'h2D -> leds FFFF for 8 clks, 0000 for 8 clks, repeated twice; then SHOW with "2d", leds 0.
REQ-036 err_in and res_valid(res_in=6'h05) same cycle -> ERR blink, then SHOW with digit0 0100100, digit1 0000001.
REQ-037 err_in 10 clks into ERR -> episode restarts: 32 further clks of blinking before exit.
REQ-038 rst pulsed mid-ERR -> anode 1111, cathode 1111111, leds 0 at once; after release IDLE dashes.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU display/LED controller: state encoding,
// segment glyphs and LED/anode constants.
package alsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_ERR  = 2'd2
    } disp_state_t;

    // Segment patterns are {a,b,c,d,e,f,g}, active-low.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_R     = 7'b1111010;

    localparam logic [3:0]  ANODE_OFF = 4'b1111;
    localparam logic [15:0] LEDS_ON   = 16'hFFFF;
    localparam logic [15:0] LEDS_OFF  = 16'h0000;

    function automatic logic [3:0] anode_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational 4-bit to 7-segment hex decoder, active-low {a,b,c,d,e,f,g}.
module seg7_hex_dec
    import alsu_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/alsu_disp_ctrl.sv
// Drives the board's 4-digit display and LEDs from ALSU results: shows the
// latest 6-bit result in hex, dashes before any result, and blinks on errors.
module alsu_disp_ctrl
    import alsu_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000,
    parameter int ERR_BLINKS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  res_in,
    input  logic        res_valid,
    input  logic        err_in,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic [15:0] leds
);

    localparam int RW      = $clog2(REFRESH_DIV);
    localparam int BW      = $clog2(BLINK_DIV);
    localparam int TOGGLES = 2 * ERR_BLINKS;
    localparam int TW      = $clog2(TOGGLES + 1);

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] TOG_LAST   = TW'(TOGGLES - 1);

    disp_state_t   state;
    logic [5:0]    value;
    logic          has_val;
    logic [BW-1:0] blink_cnt;
    logic          phase_on;
    logic [TW-1:0] toggles;

    logic [RW-1:0] ref_cnt;
    logic [1:0]    digit;

    logic [6:0]    seg_lo;
    logic [6:0]    seg_hi;
    logic [6:0]    seg_next;
    logic          blink_tc;

    seg7_hex_dec u_dec_lo (
        .hex (value[3:0]),
        .seg (seg_lo)
    );

    seg7_hex_dec u_dec_hi (
        .hex ({2'b00, value[5:4]}),
        .seg (seg_hi)
    );

    assign blink_tc = (blink_cnt == BLINK_LAST);

    // Mode control, value capture and error-blink timing. An error strobe
    // always (re)starts a full episode, even when one is already running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            value     <= '0;
            has_val   <= 1'b0;
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            toggles   <= '0;
            leds      <= LEDS_OFF;
        end else begin
            if (res_valid) begin
                value   <= res_in;
                has_val <= 1'b1;
            end

            if (err_in) begin
                state     <= ST_ERR;
                blink_cnt <= '0;
                phase_on  <= 1'b1;
                toggles   <= '0;
                leds      <= LEDS_ON;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (res_valid) begin
                            state <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                    end
                    ST_ERR: begin
                        if (blink_tc) begin
                            blink_cnt <= '0;
                            if (toggles == TOG_LAST) begin
                                state    <= (has_val || res_valid) ? ST_SHOW : ST_IDLE;
                                toggles  <= '0;
                                phase_on <= 1'b1;
                                leds     <= LEDS_OFF;
                            end else begin
                                toggles  <= toggles + 1'b1;
                                phase_on <= ~phase_on;
                                leds     <= phase_on ? LEDS_OFF : LEDS_ON;
                            end
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Glyph for the digit being latched at the next slot boundary.
    always_comb begin
        seg_next = SEG_BLANK;
        case (state)
            ST_IDLE: seg_next = SEG_DASH;
            ST_SHOW: begin
                if (digit == 2'd0) begin
                    seg_next = seg_lo;
                end else if (digit == 2'd1) begin
                    seg_next = seg_hi;
                end
            end
            ST_ERR: begin
                if (phase_on) begin
                    case (digit)
                        2'd3:       seg_next = SEG_E;
                        2'd2, 2'd1: seg_next = SEG_R;
                        default:    seg_next = SEG_BLANK;
                    endcase
                end
            end
            default: seg_next = SEG_BLANK;
        endcase
    end

    // Digit scan: the slot for the current index is latched at terminal
    // count, so after reset digit0 is the first one to light.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt <= '0;
            digit   <= 2'd0;
            anode   <= ANODE_OFF;
            cathode <= SEG_BLANK;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            digit   <= digit + 1'b1;
            anode   <= anode_sel(digit);
            cathode <= seg_next;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

endmodule
